// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion, flush and hold control.
// Optional bubble counter is enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pause_in,
   input  logic              flush,
   input  logic              ex_hold,
   input  logic              id_valid,
   input  logic [DATA_W-1:0] id_pc,
   input  logic [DATA_W-1:0] id_r1_data,
   input  logic [DATA_W-1:0] id_r2_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [4:0]        id_wa,
   input  logic              id_we,
   input  logic [1:0]        id_cregwd,
   input  logic [3:0]        id_alu_op,
   input  logic              id_mem_we,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_pc,
   output logic [DATA_W-1:0] ex_r1,
   output logic [DATA_W-1:0] ex_r2,
   output logic [DATA_W-1:0] ex_imm,
   output logic [4:0]        ex_wa,
   output logic              ex_we,
   output logic [1:0]        ex_cregwd,
   output logic [3:0]        ex_alu_op,
   output logic              ex_mem_we,
`ifdef ID_EX_PERF_CNT_EN
   output logic              stall_if,
   output logic [15:0]       bubble_cnt
`else
   output logic              stall_if
`endif
);

   logic              valid_reg,  valid_next;
   logic [DATA_W-1:0] pc_reg,     pc_next;
   logic [DATA_W-1:0] r1_reg,     r1_next;
   logic [DATA_W-1:0] r2_reg,     r2_next;
   logic [DATA_W-1:0] imm_reg,    imm_next;
   logic [4:0]        wa_reg,     wa_next;
   logic              we_reg,     we_next;
   logic [1:0]        cregwd_reg, cregwd_next;
   logic [3:0]        alu_op_reg, alu_op_next;
   logic              mem_we_reg, mem_we_next;

   logic insert_bubble;
   logic load_instr;

   // Flush wins over hold; a pause only produces a bubble when EX is not frozen.
   assign insert_bubble = flush | (~ex_hold & pause_in);
   assign load_instr    = ~flush & ~ex_hold & ~pause_in;

   always_comb begin
      valid_next  = valid_reg;
      pc_next     = pc_reg;
      r1_next     = r1_reg;
      r2_next     = r2_reg;
      imm_next    = imm_reg;
      wa_next     = wa_reg;
      we_next     = we_reg;
      cregwd_next = cregwd_reg;
      alu_op_next = alu_op_reg;
      mem_we_next = mem_we_reg;
      if (insert_bubble) begin
         valid_next  = 1'b0;
         pc_next     = id_pc;
         r1_next     = id_r1_data;
         r2_next     = id_r2_data;
         imm_next    = id_imm;
         wa_next     = 5'd0;
         we_next     = 1'b0;
         cregwd_next = 2'd0;
         alu_op_next = 4'd0;
         mem_we_next = 1'b0;
      end else if (load_instr) begin
         valid_next  = id_valid;
         pc_next     = id_pc;
         r1_next     = id_r1_data;
         r2_next     = id_r2_data;
         imm_next    = id_imm;
         wa_next     = id_wa;
         we_next     = id_we & id_valid;
         cregwd_next = id_cregwd;
         alu_op_next = id_alu_op;
         mem_we_next = id_mem_we & id_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg  <= 1'b0;
         pc_reg     <= '0;
         r1_reg     <= '0;
         r2_reg     <= '0;
         imm_reg    <= '0;
         wa_reg     <= 5'd0;
         we_reg     <= 1'b0;
         cregwd_reg <= 2'd0;
         alu_op_reg <= 4'd0;
         mem_we_reg <= 1'b0;
      end else begin
         valid_reg  <= valid_next;
         pc_reg     <= pc_next;
         r1_reg     <= r1_next;
         r2_reg     <= r2_next;
         imm_reg    <= imm_next;
         wa_reg     <= wa_next;
         we_reg     <= we_next;
         cregwd_reg <= cregwd_next;
         alu_op_reg <= alu_op_next;
         mem_we_reg <= mem_we_next;
      end
   end

   assign ex_valid  = valid_reg;
   assign ex_pc     = pc_reg;
   assign ex_r1     = r1_reg;
   assign ex_r2     = r2_reg;
   assign ex_imm    = imm_reg;
   assign ex_wa     = wa_reg;
   assign ex_we     = we_reg;
   assign ex_cregwd = cregwd_reg;
   assign ex_alu_op = alu_op_reg;
   assign ex_mem_we = mem_we_reg;

   assign stall_if = ~rst & ~flush & (pause_in | ex_hold);

`ifdef ID_EX_PERF_CNT_EN
   logic [15:0] bubble_cnt_reg;
   logic        pause_bubble;

   // Only genuine load-use bubbles are counted; flush bubbles are not.
   assign pause_bubble = ~flush & ~ex_hold & pause_in;

   always_ff @(posedge clk) begin
      if (rst) begin
         bubble_cnt_reg <= 16'd0;
      end else if (pause_bubble && (bubble_cnt_reg != 16'hFFFF)) begin
         bubble_cnt_reg <= bubble_cnt_reg + 16'd1;
      end
   end

   assign bubble_cnt = bubble_cnt_reg;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a driver pushes expected results from a
// behavioural model, two monitors pop and compare stall_if and the EX state.
module tb_id_ex_stage;

   localparam int DATA_W = 32;

   typedef struct packed {
      logic              rst;
      logic              pause;
      logic              flush;
      logic              hold;
      logic              valid;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] r1;
      logic [DATA_W-1:0] r2;
      logic [DATA_W-1:0] imm;
      logic [4:0]        wa;
      logic              we;
      logic [1:0]        cregwd;
      logic [3:0]        alu;
      logic              mem_we;
   } in_t;

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] r1;
      logic [DATA_W-1:0] r2;
      logic [DATA_W-1:0] imm;
      logic [4:0]        wa;
      logic              we;
      logic [1:0]        cregwd;
      logic [3:0]        alu;
      logic              mem_we;
      logic [15:0]       cnt;
   } st_t;

   logic              clk = 1'b0;
   logic              rst, pause_in, flush, ex_hold, id_valid;
   logic [DATA_W-1:0] id_pc, id_r1_data, id_r2_data, id_imm;
   logic [4:0]        id_wa;
   logic              id_we, id_mem_we;
   logic [1:0]        id_cregwd;
   logic [3:0]        id_alu_op;
   logic              ex_valid, ex_we, ex_mem_we, stall_if;
   logic [DATA_W-1:0] ex_pc, ex_r1, ex_r2, ex_imm;
   logic [4:0]        ex_wa;
   logic [1:0]        ex_cregwd;
   logic [3:0]        ex_alu_op;
   logic [15:0]       cnt_obs;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   st_t  model;
   st_t  state_q[$];
   logic stall_q[$];

   always #5 clk = ~clk;

   id_ex_stage #(.DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst), .pause_in(pause_in), .flush(flush), .ex_hold(ex_hold),
      .id_valid(id_valid), .id_pc(id_pc), .id_r1_data(id_r1_data),
      .id_r2_data(id_r2_data), .id_imm(id_imm), .id_wa(id_wa), .id_we(id_we),
      .id_cregwd(id_cregwd), .id_alu_op(id_alu_op), .id_mem_we(id_mem_we),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_r1(ex_r1), .ex_r2(ex_r2),
      .ex_imm(ex_imm), .ex_wa(ex_wa), .ex_we(ex_we), .ex_cregwd(ex_cregwd),
      .ex_alu_op(ex_alu_op), .ex_mem_we(ex_mem_we),
`ifdef ID_EX_PERF_CNT_EN
      .stall_if(stall_if), .bubble_cnt(cnt_obs)
`else
      .stall_if(stall_if)
`endif
   );

`ifndef ID_EX_PERF_CNT_EN
   assign cnt_obs = 16'd0;
`endif

   function automatic in_t idle();
      in_t s;
      s = '0;
      return s;
   endfunction

   function automatic in_t rnd();
      in_t s;
      s.rst    = ($urandom_range(0, 49) == 0);
      s.flush  = ($urandom_range(0, 9) == 0);
      s.hold   = ($urandom_range(0, 4) == 0);
      s.pause  = ($urandom_range(0, 3) == 0);
      s.valid  = ($urandom_range(0, 4) != 0);
      s.pc     = $urandom;
      s.r1     = $urandom;
      s.r2     = $urandom;
      s.imm    = $urandom;
      s.wa     = 5'($urandom);
      s.we     = 1'($urandom);
      s.cregwd = 2'($urandom);
      s.alu    = 4'($urandom);
      s.mem_we = 1'($urandom);
      return s;
   endfunction

   // Reference: what the EX register holds after the coming edge, given the inputs.
   task automatic drive(input in_t s);
      st_t  nx;
      logic stall_exp;
      @(posedge clk);
      #2;
      rst = s.rst; pause_in = s.pause; flush = s.flush; ex_hold = s.hold;
      id_valid = s.valid; id_pc = s.pc; id_r1_data = s.r1; id_r2_data = s.r2;
      id_imm = s.imm; id_wa = s.wa; id_we = s.we; id_cregwd = s.cregwd;
      id_alu_op = s.alu; id_mem_we = s.mem_we;
      nx = model;
      if (s.rst) begin
         nx = '0;
      end else if (s.flush || (!s.hold && s.pause)) begin
         nx.valid = 0; nx.we = 0; nx.mem_we = 0; nx.cregwd = 0; nx.alu = 0; nx.wa = 0;
         nx.pc = s.pc; nx.r1 = s.r1; nx.r2 = s.r2; nx.imm = s.imm;
`ifdef ID_EX_PERF_CNT_EN
         if (!s.flush && model.cnt < 16'hFFFF) nx.cnt = model.cnt + 16'd1;
`endif
      end else if (!s.hold) begin
         nx.valid = s.valid; nx.pc = s.pc; nx.r1 = s.r1; nx.r2 = s.r2; nx.imm = s.imm;
         nx.wa = s.wa; nx.cregwd = s.cregwd; nx.alu = s.alu;
         nx.we = s.valid ? s.we : 1'b0;
         nx.mem_we = s.valid ? s.mem_we : 1'b0;
      end
      stall_exp = s.rst ? 1'b0 : (!s.flush && (s.pause || s.hold));
      model = nx;
      state_q.push_back(nx);
      stall_q.push_back(stall_exp);
      cyc++;
   endtask

   // stall_if monitor: inputs settle at posedge+2, sampled on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (stall_q.size() > 0) begin
            logic e;
            e = stall_q.pop_front();
            n_tests++;
            if (stall_if !== e) begin
               n_fail++;
               $display("FAIL stall_if cyc=%0d got=%b exp=%b", cyc, stall_if, e);
            end
         end
      end
   end

   // EX register monitor: the item pushed last cycle matures at this edge.
   initial begin
      forever begin
         st_t act, e;
         @(posedge clk);
         #1;
         if (state_q.size() > 0) begin
            e = state_q.pop_front();
            act = {ex_valid, ex_pc, ex_r1, ex_r2, ex_imm, ex_wa, ex_we, ex_cregwd,
                   ex_alu_op, ex_mem_we, cnt_obs};
            n_tests++;
            if (act !== e) begin
               n_fail++;
               $display("FAIL ex_state cyc=%0d got=%h exp=%h", cyc, act, e);
            end
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      in_t s;
      model = '0;
      rst = 1; pause_in = 0; flush = 0; ex_hold = 0; id_valid = 0;
      id_pc = '0; id_r1_data = '0; id_r2_data = '0; id_imm = '0; id_wa = '0;
      id_we = 0; id_cregwd = '0; id_alu_op = '0; id_mem_we = 0;

      // Reset with a live write request on the inputs
      s = idle(); s.rst = 1; s.we = 1; s.wa = 5; s.valid = 1; drive(s);
      // Plain load
      s = idle(); s.valid = 1; s.pc = 32'h100; s.r1 = 32'hDEAD; s.wa = 8; s.we = 1; drive(s);
      // Two-cycle load-use pause, then the paused instruction loads
      s = idle(); s.valid = 1; s.pc = 32'h104; s.we = 1; s.wa = 3; s.pause = 1;
      drive(s); drive(s);
      s.pause = 0; drive(s);
      // Flush beats pause and hold
      s = idle(); s.valid = 1; s.we = 1; s.pc = 32'h108; s.wa = 4;
      s.flush = 1; s.pause = 1; s.hold = 1; drive(s);
      // Load 0x200 then hold for three cycles with changing inputs and pause
      s = idle(); s.valid = 1; s.pc = 32'h200; s.r1 = 32'h11; s.wa = 9; s.we = 1;
      s.mem_we = 1; s.alu = 4'hA; s.cregwd = 2; drive(s);
      for (int i = 0; i < 3; i++) begin
         s = rnd(); s.rst = 0; s.flush = 0; s.hold = 1; s.pause = 1; drive(s);
      end
      // Invalid instruction under load masks its write enables
      s = idle(); s.valid = 0; s.we = 1; s.mem_we = 1; s.pc = 32'h300; s.wa = 7; drive(s);
      // Reset in the middle of a hold, then a normal load
      s = idle(); s.hold = 1; s.pause = 1; drive(s);
      s.rst = 1; drive(s);
      s = idle(); s.valid = 1; s.pc = 32'h400; s.we = 1; s.wa = 2; drive(s);

      for (int i = 0; i < 400; i++) drive(rnd());

`ifdef ID_EX_PERF_CNT_EN
      s = idle(); s.rst = 1; drive(s);
      s = idle(); s.pause = 1;
      for (int i = 0; i < 65536; i++) drive(s);
      s.pause = 0; s.valid = 1; drive(s);
`endif

      repeat (2) @(posedge clk);
      #3;
      n_tests++;
      if (state_q.size() != 0 || stall_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain got=%0d/%0d exp=0/0", state_q.size(), stall_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
